regfile_arbiter: RTL and testbench

//  Shares the single-port 16x16 register file (one address, write strobe, read strobe) between two

---
 rtl/regfile_arbiter_pkg.sv | 26 ++
 rtl/regfile_arbiter_rr_arb2.sv | 29 ++
 rtl/regfile_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the two-client register-file arbiter.
// Contents:
//   DefAw/DefDw    default address/data widths of the shared register file
//   state_e        sequencer state encoding (2-bit)
//   Client0/1      client identifiers
//   client_onehot  maps a client id to its one-hot grant/ack vector
package regfile_arbiter_pkg;

  localparam int unsigned DefAw = 4;
  localparam int unsigned DefDw = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam logic Client0 = 1'b0;
  localparam logic Client1 = 1'b1;

  function automatic logic [1:0] client_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req   in  2  per-client request
//   last  in  1  client granted most recently (the other one wins a tie)
//   en    in  1  grant enable; gnt is forced to zero when low
//   gnt   out 2  one-hot grant
module regfile_arbiter_rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = client_onehot(Client0);
        2'b10:   gnt = client_onehot(Client1);
        // Tie: the client that did not win last time goes next.
        2'b11:   gnt = last ? client_onehot(Client0) : client_onehot(Client1);
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a single-port register file between two clients. A round-robin picker
// chooses a client in IDLE; a four-state sequencer (IDLE, SETUP, STROBE, HOLD)
// then presents the latched address/data, pulses exactly one strobe for one cycle,
// and acknowledges the owner during HOLD.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req[1:0]          per-client level request, held until granted
//   we[1:0]           per-client op: 1 = write, 0 = read
//   addr0/1, wdata0/1 per-client operands
//   gnt[1:0]          combinational one-hot accept (IDLE only)
//   ack[1:0]          registered one-cycle completion pulse (during HOLD)
//   rdata             registered read result, valid with ack
//   busy              high whenever the sequencer is not idle
//   rf_addr, rf_din   register file address / write data (registered)
//   rf_wstb, rf_rstb  register file write / read strobes (registered)
//   rf_dout           register file read data
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_din,
  output logic          rf_wstb,
  output logic          rf_rstb,
  input  logic [DW-1:0] rf_dout
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    ack_q, ack_d;
  logic          wstb_q, wstb_d;
  logic          rstb_q, rstb_d;

  logic [1:0]    gnt_int;
  logic          arb_en;
  logic          accept;
  logic          sel;

  // Grants only exist in IDLE and never while reset is being applied.
  assign arb_en = (state_q == StIdle) && rst_n;

  regfile_arbiter_rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .en   (arb_en),
    .gnt  (gnt_int)
  );

  assign accept = |(req & gnt_int);
  assign sel    = gnt_int[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    ack_d   = 2'b00;
    wstb_d  = 1'b0;
    rstb_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = sel;
          we_d    = we[sel];
          addr_d  = sel ? addr1 : addr0;
          din_d   = sel ? wdata1 : wdata0;
          last_d  = sel;
          state_d = StSetup;
        end
      end
      StSetup: begin
        // Strobes are registered, so they are launched one state early.
        wstb_d  = we_q;
        rstb_d  = ~we_q;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (!we_q) begin
          rdata_d = rf_dout;
        end
        ack_d   = client_onehot(owner_q);
        state_d = StHold;
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= Client0;
      we_q    <= 1'b0;
      last_q  <= Client1;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 2'b00;
      wstb_q  <= 1'b0;
      rstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      wstb_q  <= wstb_d;
      rstb_q  <= rstb_d;
    end
  end

  assign gnt     = gnt_int;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != StIdle);
  assign rf_addr = addr_q;
  assign rf_din  = din_q;
  assign rf_wstb = wstb_q;
  assign rf_rstb = rstb_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x16 register file.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, ack;
  logic [15:0] rdata;
  logic        busy;
  logic [3:0]  rf_addr;
  logic [15:0] rf_din;
  logic        rf_wstb, rf_rstb;
  logic [15:0] rf_dout;

  always #5 clk = ~clk;

  regfile_arbiter #(
    .AW (4),
    .DW (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt     (gnt),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .rf_addr (rf_addr),
    .rf_din  (rf_din),
    .rf_wstb (rf_wstb),
    .rf_rstb (rf_rstb),
    .rf_dout (rf_dout)
  );

  // Register file model: write on a clock edge where the write strobe is high,
  // asynchronous read of the addressed word.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (rf_wstb) mem[rf_addr] <= rf_din;
  end
  assign rf_dout = mem[rf_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        cl;
    logic        w;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        perturb;
  } vec_t;

  vec_t vecs[$];

  // Called at a negedge with req already driven; returns at the negedge of SETUP.
  task automatic wait_accept(input logic [1:0] oh, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (gnt == oh) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("grant_timeout", 32'(gnt), 32'(oh));
      req = 2'b00;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req = 2'b00;
    end
  endtask

  task automatic run_op(input vec_t v);
    logic [1:0] oh;
    bit ok;
    oh = v.cl ? 2'b10 : 2'b01;
    we[v.cl] = v.w;
    if (v.cl) begin
      addr1 = v.a; wdata1 = v.d;
    end else begin
      addr0 = v.a; wdata0 = v.d;
    end
    req = oh;
    wait_accept(oh, ok);
    if (!ok) return;
    if (v.perturb) begin
      if (v.cl) begin
        addr1 = ~v.a; wdata1 = ~v.d; we[1] = ~v.w;
      end else begin
        addr0 = ~v.a; wdata0 = ~v.d; we[0] = ~v.w;
      end
    end
    #1;
    // SETUP
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_addr", 32'(rf_addr), 32'(v.a));
    check("setup_strobes", 32'({rf_wstb, rf_rstb}), 32'd0);
    check("setup_ack", 32'(ack), 32'd0);
    if (v.w) check("setup_din", 32'(rf_din), 32'(v.d));
    // STROBE
    @(negedge clk);
    check("strobe_strobes", 32'({rf_wstb, rf_rstb}), 32'({v.w, ~v.w}));
    check("strobe_addr", 32'(rf_addr), 32'(v.a));
    check("strobe_ack", 32'(ack), 32'd0);
    // HOLD: third cycle after the accept edge
    @(negedge clk);
    check("hold_ack", 32'(ack), 32'(oh));
    check("hold_strobes", 32'({rf_wstb, rf_rstb}), 32'd0);
    check("hold_addr", 32'(rf_addr), 32'(v.a));
    if (v.w) check("hold_din", 32'(rf_din), 32'(v.d));
    else     check("hold_rdata", 32'(rdata), 32'(v.exp_rd));
    // back to IDLE, address still held
    @(negedge clk);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_addr", 32'(rf_addr), 32'(v.a));
  endtask

  task automatic op(input logic cl, input logic w, input logic [3:0] a, input logic [15:0] d,
                    input logic [15:0] exp_rd);
    vec_t v;
    v = '{cl, w, a, d, exp_rd, 1'b0};
    run_op(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, cyc, last_cyc, idle_run, max_idle;

    // Stimulus table
    vecs.push_back('{1'b0, 1'b1, 4'd5, 16'hA5A5, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd5, 16'h0000, 16'hA5A5, 1'b0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 1'b1, 4'(i), 16'(16'h1000 + i), 16'h0000, 1'b0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 1'b0, 4'(i), 16'h0000, 16'(16'h1000 + i), 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd7, 16'h7777, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'd7, 16'h0000, 16'h7777, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd9, 16'h0000, 16'h1009, 1'b0});

    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00;
    addr0 = 4'd0; addr1 = 4'd0; wdata0 = 16'h0; wdata1 = 16'h0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rf_addr", 32'(rf_addr), 32'd0);
    check("rst_rf_din", 32'(rf_din), 32'd0);
    check("rst_strobes", 32'({rf_wstb, rf_rstb}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven ops
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // Fairness: both clients requesting continuously, starting from reset
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 2'b00; addr0 = 4'd1; addr1 = 4'd2;
    req = 2'b11;
    n = 0; cyc = 0; last_cyc = 0; idle_run = 0; max_idle = 0;
    while (n < 8 && cyc < 100) begin
      #1;
      if (!busy) idle_run++;
      else idle_run = 0;
      if (idle_run > max_idle) max_idle = idle_run;
      if (gnt != 2'b00) begin
        check("rr_order", 32'(gnt), (n % 2 == 1) ? 32'd2 : 32'd1);
        if (n > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        n++;
      end
      if (n == 8) begin
        @(posedge clk);
        #1 req = 2'b00;
      end
      @(negedge clk);
      cyc++;
    end
    check("rr_count", 32'(n), 32'd8);
    check("rr_max_idle", 32'(max_idle), 32'd1);
    repeat (5) @(negedge clk);

    // Reset during STROBE of a write: write reaches the regfile, no ack
    op(1'b0, 1'b1, 4'd3, 16'h0033, 16'h0000);
    we[0] = 1'b1; addr0 = 4'd3; wdata0 = 16'hDEAD;
    req = 2'b01;
    wait_accept(2'b01, ok);
    @(negedge clk);
    check("rstA_strobe_wstb", 32'(rf_wstb), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstA_busy", 32'(busy), 32'd0);
    check("rstA_strobes", 32'({rf_wstb, rf_rstb}), 32'd0);
    check("rstA_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstA_no_late_ack", 32'(ack), 32'd0);
    op(1'b0, 1'b0, 4'd3, 16'h0000, 16'hDEAD);

    // Reset during SETUP of a write: regfile keeps its prior value
    op(1'b1, 1'b1, 4'd3, 16'h0033, 16'h0000);
    we[1] = 1'b1; addr1 = 4'd3; wdata1 = 16'hBEEF;
    req = 2'b10;
    wait_accept(2'b10, ok);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstB_busy", 32'(busy), 32'd0);
    check("rstB_strobes", 32'({rf_wstb, rf_rstb}), 32'd0);
    check("rstB_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstB_no_late_ack", 32'(ack), 32'd0);
    op(1'b0, 1'b0, 4'd3, 16'h0000, 16'h0033);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
